// File: rtl/control_unit.sv
// Hardwired CPU control FSM: three-step fetch (T0-T2) followed by up to five
// opcode-specific execute steps (T3-T7), with a pause on stop and a terminal HALT.
module control_unit #(
    parameter int              OP_W    = 5,
    parameter logic [OP_W-1:0] ALU_ADD = 5'b00011
) (
    input  logic            clk,
    input  logic            clr,
    input  logic [31:0]     IR_Data,
    input  logic            con_output,
    input  logic            stop,
    output logic            run,
    output logic            PC_enable,
    output logic            PC_increment_enable,
    output logic            IR_enable,
    output logic            con_enable,
    output logic            Y_enable,
    output logic            Z_enable,
    output logic            MAR_enable,
    output logic            MDR_enable,
    output logic            HI_enable,
    output logic            LO_enable,
    output logic            manual_R15_enable,
    output logic            outport_enable,
    output logic            read,
    output logic            write,
    output logic            Gra,
    output logic            Grb,
    output logic            Grc,
    output logic            r_enable,
    output logic            r_select,
    output logic            BAout,
    output logic            PC_select,
    output logic            HI_select,
    output logic            LO_select,
    output logic            Z_HI_select,
    output logic            Z_LO_select,
    output logic            MDR_select,
    output logic            inport_select,
    output logic            c_select,
    output logic [OP_W-1:0] alu_instruction
);

    typedef enum logic [3:0] {T0, T1, T2, T3, T4, T5, T6, T7, HALT} state_t;

    localparam logic [OP_W-1:0] OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010;
    localparam logic [OP_W-1:0] OP_ADD  = 5'b00011, OP_SHL  = 5'b01011;
    localparam logic [OP_W-1:0] OP_ADDI = 5'b01100, OP_ORI  = 5'b01110;
    localparam logic [OP_W-1:0] OP_DIV  = 5'b01111, OP_MUL  = 5'b10000;
    localparam logic [OP_W-1:0] OP_NEG  = 5'b10001, OP_NOT  = 5'b10010;
    localparam logic [OP_W-1:0] OP_BR   = 5'b10011, OP_JR   = 5'b10100, OP_JAL  = 5'b10101;
    localparam logic [OP_W-1:0] OP_IN   = 5'b10110, OP_OUT  = 5'b10111;
    localparam logic [OP_W-1:0] OP_MFHI = 5'b11000, OP_MFLO = 5'b11001, OP_HALT = 5'b11011;

    state_t          state, next;
    logic [OP_W-1:0] opcode;
    logic            ir_unused;
    logic            is_r, is_i, is_ldi, is_ld, is_st, is_muldiv, is_neg, is_br;
    logic            is_jr, is_jal, is_in, is_out, is_mfhi, is_mflo, is_halt, has_exec;

    assign opcode    = IR_Data[31 -: OP_W];
    assign ir_unused = ^IR_Data[31-OP_W:0];

    assign is_r      = (opcode >= OP_ADD) && (opcode <= OP_SHL);
    assign is_i      = (opcode >= OP_ADDI) && (opcode <= OP_ORI);
    assign is_ldi    = (opcode == OP_LDI);
    assign is_ld     = (opcode == OP_LD);
    assign is_st     = (opcode == OP_ST);
    assign is_muldiv = (opcode == OP_DIV) || (opcode == OP_MUL);
    assign is_neg    = (opcode == OP_NEG) || (opcode == OP_NOT);
    assign is_br     = (opcode == OP_BR);
    assign is_jr     = (opcode == OP_JR);
    assign is_jal    = (opcode == OP_JAL);
    assign is_in     = (opcode == OP_IN);
    assign is_out    = (opcode == OP_OUT);
    assign is_mfhi   = (opcode == OP_MFHI);
    assign is_mflo   = (opcode == OP_MFLO);
    assign is_halt   = (opcode == OP_HALT);
    // nop and undefined opcodes have no execute steps and fall straight back to T0.
    assign has_exec  = is_r | is_i | is_ldi | is_ld | is_st | is_muldiv | is_neg | is_br |
                       is_jr | is_jal | is_in | is_out | is_mfhi | is_mflo;

    always_ff @(posedge clk) begin
        if (clr) state <= T0;
        else     state <= next;
    end

    always_comb begin
        next                = state;
        run                 = 1'b0;
        PC_enable           = 1'b0;
        PC_increment_enable = 1'b0;
        IR_enable           = 1'b0;
        con_enable          = 1'b0;
        Y_enable            = 1'b0;
        Z_enable            = 1'b0;
        MAR_enable          = 1'b0;
        MDR_enable          = 1'b0;
        HI_enable           = 1'b0;
        LO_enable           = 1'b0;
        manual_R15_enable   = 1'b0;
        outport_enable      = 1'b0;
        read                = 1'b0;
        write               = 1'b0;
        Gra                 = 1'b0;
        Grb                 = 1'b0;
        Grc                 = 1'b0;
        r_enable            = 1'b0;
        r_select            = 1'b0;
        BAout               = 1'b0;
        PC_select           = 1'b0;
        HI_select           = 1'b0;
        LO_select           = 1'b0;
        Z_HI_select         = 1'b0;
        Z_LO_select         = 1'b0;
        MDR_select          = 1'b0;
        inport_select       = 1'b0;
        c_select            = 1'b0;
        alu_instruction     = '0;

        // clr, HALT and a stalled T0 all present a fully quiet control word.
        if (!clr && state != HALT && !(state == T0 && stop)) begin
            run             = 1'b1;
            alu_instruction = (is_ld | is_ldi | is_st | is_br) ? ALU_ADD : opcode;
            case (state)
                T0: begin
                    PC_select = 1'b1; MAR_enable = 1'b1; PC_increment_enable = 1'b1;
                    next = T1;
                end
                T1: begin
                    read = 1'b1; MDR_enable = 1'b1;
                    next = T2;
                end
                T2: begin
                    MDR_select = 1'b1; IR_enable = 1'b1;
                    next = is_halt ? HALT : (has_exec ? T3 : T0);
                end
                T3: begin
                    next = T4;
                    if (is_r || is_i) begin
                        Grb = 1'b1; r_select = 1'b1; Y_enable = 1'b1;
                    end else if (is_ldi || is_ld || is_st) begin
                        Grb = 1'b1; BAout = 1'b1; Y_enable = 1'b1;
                    end else if (is_muldiv) begin
                        Gra = 1'b1; r_select = 1'b1; Y_enable = 1'b1;
                    end else if (is_neg) begin
                        Grb = 1'b1; r_select = 1'b1; Z_enable = 1'b1;
                    end else if (is_br) begin
                        Gra = 1'b1; r_select = 1'b1; con_enable = 1'b1;
                    end else if (is_jal) begin
                        PC_select = 1'b1; manual_R15_enable = 1'b1;
                    end else begin
                        next = T0;
                        if (is_jr)   begin Gra = 1'b1; r_select = 1'b1; PC_enable = 1'b1; end
                        if (is_in)   begin inport_select = 1'b1; Gra = 1'b1; r_enable = 1'b1; end
                        if (is_out)  begin Gra = 1'b1; r_select = 1'b1; outport_enable = 1'b1; end
                        if (is_mfhi) begin HI_select = 1'b1; Gra = 1'b1; r_enable = 1'b1; end
                        if (is_mflo) begin LO_select = 1'b1; Gra = 1'b1; r_enable = 1'b1; end
                    end
                end
                T4: begin
                    next = T5;
                    if (is_r) begin
                        Grc = 1'b1; r_select = 1'b1; Z_enable = 1'b1;
                    end else if (is_i || is_ldi || is_ld || is_st) begin
                        c_select = 1'b1; Z_enable = 1'b1;
                    end else if (is_muldiv) begin
                        Grb = 1'b1; r_select = 1'b1; Z_enable = 1'b1;
                    end else if (is_br) begin
                        PC_select = 1'b1; Y_enable = 1'b1;
                    end else begin
                        next = T0;
                        if (is_neg) begin Z_LO_select = 1'b1; Gra = 1'b1; r_enable = 1'b1; end
                        if (is_jal) begin Gra = 1'b1; r_select = 1'b1; PC_enable = 1'b1; end
                    end
                end
                T5: begin
                    next = T6;
                    if (is_ld || is_st) begin
                        Z_LO_select = 1'b1; MAR_enable = 1'b1;
                    end else if (is_muldiv) begin
                        Z_LO_select = 1'b1; LO_enable = 1'b1;
                    end else if (is_br) begin
                        c_select = 1'b1; Z_enable = 1'b1;
                    end else begin
                        next = T0;
                        if (is_r || is_i || is_ldi) begin
                            Z_LO_select = 1'b1; Gra = 1'b1; r_enable = 1'b1;
                        end
                    end
                end
                T6: begin
                    next = T0;
                    if (is_ld) begin
                        read = 1'b1; MDR_enable = 1'b1; next = T7;
                    end else if (is_st) begin
                        Gra = 1'b1; r_select = 1'b1; MDR_enable = 1'b1; next = T7;
                    end else if (is_muldiv) begin
                        Z_HI_select = 1'b1; HI_enable = 1'b1;
                    end else if (is_br) begin
                        Z_LO_select = 1'b1; PC_enable = con_output;
                    end
                end
                T7: begin
                    next = T0;
                    if (is_ld) begin
                        MDR_select = 1'b1; Gra = 1'b1; r_enable = 1'b1;
                    end else if (is_st) begin
                        write = 1'b1;
                    end
                end
                default: next = T0;
            endcase
        end
    end

endmodule
